// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, round constants, FSM encoding and S-box table.
package aes_pkg;
  typedef logic [15:0][7:0] state_t;
  typedef logic [3:0][7:0] word_t;
  typedef enum logic {NOKEY, RUN} fsm_e;
  localparam logic [3:0] NR = 4'd10;
  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
endpackage

// File: rtl/key_expand_step.sv
// key_expand_step: one combinational AES-128 key-schedule round (four S-box lookups plus XOR chain).
module key_expand_step
  import aes_pkg::*;
(
  input  state_t     key_i,
  input  logic [7:0] rcon_i,
  output state_t     next_o
);
  word_t w3, sub, t, w0n, w1n, w2n, w3n;
  assign w3 = key_i[15:12];
  // RotWord folded into the lookup index: output byte i takes input byte i+1.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[i] = SBOX[w3[(i + 1) % 4]];
  end
  assign t = sub ^ {24'h0, rcon_i};
  assign w0n = key_i[3:0] ^ t;
  assign w1n = key_i[7:4] ^ w0n;
  assign w2n = key_i[11:8] ^ w1n;
  assign w3n = w3 ^ w2n;
  assign next_o = {w3n, w2n, w1n, w0n};
endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage: AES-128 AddRoundKey with on-the-fly key schedule and registered valid/ready output.
module add_round_key_stage
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_load,
  input  state_t     cipher_key,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     state_in,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     state_out,
  output logic [3:0] out_round,
  output logic       key_valid
);
  fsm_e fsm_q, fsm_d;
  state_t cipher_q, cipher_d, rkey_q, rkey_d, next_key, out_q, out_d;
  logic [3:0] round_q, round_d, oround_q, oround_d;
  logic ovalid_q, ovalid_d, fire, last;
  logic [7:0] rcon;
  assign last = (round_q == NR);
  assign rcon = last ? 8'h00 : RCON[round_q];
  key_expand_step u_step (.key_i(rkey_q), .rcon_i(rcon), .next_o(next_key));
  always_comb begin
    in_ready = (fsm_q == RUN) && !key_load && (!ovalid_q || out_ready);
    fire = in_valid && in_ready;
    fsm_d = key_load ? RUN : fsm_q;
    cipher_d = key_load ? cipher_key : cipher_q;
    // After round 10 the schedule rewinds to the stored cipher key for the next block.
    rkey_d = key_load ? cipher_key : fire ? (last ? cipher_q : next_key) : rkey_q;
    round_d = key_load ? 4'd0 : fire ? (last ? 4'd0 : round_q + 4'd1) : round_q;
    out_d = fire ? state_in ^ rkey_q : out_q;
    oround_d = fire ? round_q : oround_q;
    ovalid_d = fire || (ovalid_q && !out_ready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= NOKEY;
      cipher_q <= '0;
      rkey_q <= '0;
      round_q <= '0;
      out_q <= '0;
      oround_q <= '0;
      ovalid_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cipher_q <= cipher_d;
      rkey_q <= rkey_d;
      round_q <= round_d;
      out_q <= out_d;
      oround_q <= oround_d;
      ovalid_q <= ovalid_d;
    end
  end
  assign out_valid = ovalid_q;
  assign state_out = out_q;
  assign out_round = oround_q;
  assign key_valid = (fsm_q == RUN);
endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage: known-answer, corner-case and randomized checks against a FIPS-197 style model.
module tb_add_round_key_stage;
  import aes_pkg::*;
  logic clk = 1'b0, reset, key_load, in_valid, in_ready, out_valid, out_ready, key_valid;
  state_t cipher_key, state_in, state_out;
  logic [3:0] out_round;
  int n_chk = 0, n_fail = 0;
  logic [7:0] sbox_m [256];

  add_round_key_stage dut (.clk(clk), .reset(reset), .key_load(key_load), .cipher_key(cipher_key),
    .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in), .out_valid(out_valid),
    .out_ready(out_ready), .state_out(state_out), .out_round(out_round), .key_valid(key_valid));

  always #5 clk = ~clk;

  typedef struct { logic load; state_t key; state_t st; logic [3:0] rnd; state_t exp; } vec_t;
  vec_t vecs [36];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[6:0], x[7]};
    return x;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic state_t fips(input logic [127:0] h);
    state_t s;
    for (int i = 0; i < 16; i++) s[i] = h[127-8*i -: 8];
    return s;
  endfunction

  // Classic FIPS-197 word expansion w[0..43], big-endian words.
  function automatic state_t round_key(input state_t k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    state_t res;
    for (int i = 0; i < 4; i++) w[i] = {k[4*i], k[4*i+1], k[4*i+2], k[4*i+3]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) res[4*c+j] = w[4*r+c][31-8*j -: 8];
    return res;
  endfunction

  function automatic state_t rnd_st();
    logic [127:0] t = {$urandom, $urandom, $urandom, $urandom};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input state_t k);
    cipher_key = k;
    key_load = 1'b1;
    in_valid = 1'b0;
    tick();
    key_load = 1'b0;
  endtask

  task automatic xfer(input state_t st, input state_t ex, input logic [3:0] r);
    state_in = st;
    in_valid = 1'b1;
    #3;
    chk("in_ready", 128'(in_ready), 128'd1);
    tick();
    chk("out_valid", 128'(out_valid), 128'd1);
    chk("state_out", state_out, ex);
    chk("out_round", 128'(out_round), 128'(r));
  endtask

  initial begin
    state_t k1, k2, k3, s, hold;
    build_sbox();
    k1 = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    reset = 1'b1; key_load = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cipher_key = '0; state_in = rnd_st();
    tick(); tick();
    chk("rst in_ready", 128'(in_ready), 128'd0);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst key_valid", 128'(key_valid), 128'd0);
    chk("rst state_out", state_out, 128'd0);
    chk("rst out_round", 128'(out_round), 128'd0);
    reset = 1'b0;
    tick();
    chk("nokey in_ready", 128'(in_ready), 128'd0);
    chk("nokey out_valid", 128'(out_valid), 128'd0);
    // key_load cycle blocks transfers even with in_valid high
    cipher_key = k1; key_load = 1'b1;
    #3;
    chk("load in_ready", 128'(in_ready), 128'd0);
    tick();
    key_load = 1'b0;
    chk("key_valid", 128'(key_valid), 128'd1);
    chk("load out_valid", 128'(out_valid), 128'd0);
    xfer(fips(128'h3243f6a8885a308d313198a2e0370734), fips(128'h193de3bea0f4e22b9ac68d2ae9f84808), 4'd0);
    xfer(fips(128'h046681e5e0cb199a48f8d37a2806264c), fips(128'ha49c7ff2689f352b6b5bea43026a5049), 4'd1);
    // zero states through rounds 0..10 and the wrap back to round 0, back to back
    do_load(k1);
    for (int r = 0; r < 12; r++) begin
      xfer('0, round_key(k1, r % 11), 4'(r % 11));
      if (r == 1) chk("kat rk1", state_out, fips(128'ha0fafe1788542cb123a339392a6c7605));
      if (r == 10) chk("kat rk10", state_out, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
      if (r == 11) chk("kat wrap", state_out, k1);
    end
    // backpressure: output held, no acceptance, no round advance
    out_ready = 1'b0;
    s = rnd_st();
    state_in = s;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("bp in_ready", 128'(in_ready), 128'd0);
      tick();
      chk("bp out_valid", 128'(out_valid), 128'd1);
      chk("bp state_out", state_out, k1);
      chk("bp out_round", 128'(out_round), 128'd0);
    end
    out_ready = 1'b1;
    xfer(s, s ^ round_key(k1, 1), 4'd1);
    for (int r = 2; r < 5; r++) begin
      s = rnd_st();
      xfer(s, s ^ round_key(k1, r), 4'(r));
    end
    hold = s ^ round_key(k1, 4);
    // key_load at round 5 with a pending output and in_valid high
    k3 = rnd_st();
    s = rnd_st();
    cipher_key = k3; key_load = 1'b1; state_in = s; in_valid = 1'b1; out_ready = 1'b0;
    #3;
    chk("kl in_ready", 128'(in_ready), 128'd0);
    tick();
    key_load = 1'b0;
    chk("kl pend valid", 128'(out_valid), 128'd1);
    chk("kl pend data", state_out, hold);
    chk("kl pend round", 128'(out_round), 128'd4);
    out_ready = 1'b1;
    xfer(s, s ^ k3, 4'd0);
    s = rnd_st();
    xfer(s, s ^ round_key(k3, 1), 4'd1);
    // randomized table: three fresh keys, full schedule plus wrap, random idle gaps
    for (int k = 0; k < 3; k++) begin
      k2 = rnd_st();
      for (int r = 0; r < 12; r++) begin
        vecs[12*k+r].load = (r == 0);
        vecs[12*k+r].key = k2;
        vecs[12*k+r].st = rnd_st();
        vecs[12*k+r].rnd = 4'(r % 11);
        vecs[12*k+r].exp = vecs[12*k+r].st ^ round_key(k2, r % 11);
      end
    end
    for (int i = 0; i < 36; i++) begin
      if (vecs[i].load) do_load(vecs[i].key);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
        chk("idle out_valid", 128'(out_valid), 128'd0);
      end
      xfer(vecs[i].st, vecs[i].exp, vecs[i].rnd);
    end
    in_valid = 1'b0;
    tick();
    chk("drain out_valid", 128'(out_valid), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/add_round_key_stage.md
# add_round_key_stage

AES-128 AddRoundKey stage with an on-the-fly key schedule. It consumes the 128-bit state produced by the MixColumns stage, or ShiftRows output in the final round, and XORs it with the current round key. It then advances the key schedule by one round, so a full encryption needs 11 transfers, rounds 0–10. Output is registered behind a valid/ready handshake toward the next round's SubBytes.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, no other clock domains.
- key_load  in  1  one-cycle pulse; capture cipher_key.
- cipher_key  in  [15:0][7:0]  cipher key; byte 0 = first FIPS-197 byte.
- in_valid  in  1  state_in valid.
- in_ready  out  1  stage accepts state_in this cycle.
- state_in  in  [15:0][7:0]  state; byte i = row i%4, column i/4 (column-major, byte 0 first).
- out_valid  out  1  state_out valid.
- out_ready  in  1  downstream accepts state_out.
- state_out  out  [15:0][7:0]  state_in XOR round key.
- out_round  out  [3:0]  round index (0–10) of the key applied to state_out.
- key_valid  out  1  a cipher key has been loaded since reset.

## Operation
- FSM states:
  - NOKEY: the reset state. in_ready = 0.
  - RUN: entered on key_load.
  - key_load in any state: cipher_reg ← cipher_key, rkey ← cipher_key, round ← 0, state → RUN.
- key_load has priority. In a cycle with key_load = 1, in_ready = 0 and no transfer occurs.
- in_ready = (state == RUN) && !key_load && (!out_valid || out_ready).
- Transfer when in_valid && in_ready:
  - state_out ← state_in ^ rkey; out_round ← round; out_valid ← 1.
  - If round < 10: rkey ← next_key(rkey, rcon[round]), round ← round + 1.
  - If round == 10: rkey ← cipher_reg, round ← 0, ready for the next block.
- next_key computation, words w0..w3 with w0 = bytes 0–3:
  - t = SubWord(RotWord(w3)) ^ {rcon, 00, 00, 00}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - All XOR is 8-bit GF(2); no carries.
- out_valid clears when out_ready && !(new transfer).
- state_out and out_round hold while out_valid && !out_ready.
- Reset mid-block discards the partial schedule: key_valid ← 0, state → NOKEY.
- key_load mid-block:
  - Restarts the schedule at round 0.
  - A pending output already in state_out stays valid until consumed.

## Timing
- Latency: 1 cycle from transfer to out_valid.
- Throughput: one transfer per cycle under continuous out_ready.
- Key advance completes in the same edge as the transfer. next_key is a single combinational level: 4 S-box lookups plus the XOR chain.
- Reset values:
  - out_valid 0, state_out all 0, out_round 0, key_valid 0, in_ready 0.
  - rkey and cipher_reg 0; round 0; FSM NOKEY.
- key_valid rises the cycle after key_load and falls only on reset.
- Round wrap: the transfer at round 10 is followed by the round-0 key on the next cycle, with no bubble.

## Structure
- Shared package aes_pkg holds:
  - typedefs: state_t = logic [15:0][7:0], word_t = logic [3:0][7:0].
  - RCON[0:9] = 01,02,04,08,10,20,40,80,1b,36.
  - NR = 10.
  - SBOX table, shared with SubBytes.
- Sub-module key_expand_step:
  - Combinational.
  - Inputs: state_t key, byte rcon. Output: state_t next key.
  - Instantiates 4 sbox lookups.
  - Separately testable.

## Test plan
- Reset with in_valid = 1 → in_ready = 0, out_valid = 0, key_valid = 0.
- Load key 2b7e151628aed2a6abf7158809cf4f3c, then send state 3243f6a8885a308d313198a2e0370734 → state_out = 193de3bea0f4e22b9ac68d2ae9f84808, out_round = 0.
- Second transfer, state 046681e5e0cb199a48f8d37a2806264c → state_out = a49c7ff2689f352b6b5bea43026a5049, out_round = 1.
- Send all-zero states for rounds 0–10:
  - Round 1 output = a0fafe1788542cb123a339392a6c7605.
  - Round 10 output = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - The 12th transfer returns round 0 = cipher key.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 → state_out stable, in_ready = 0, round does not advance.
- key_load asserted at round 5 while in_valid = 1 → no transfer that cycle; next output has out_round = 0 and equals state_in ^ the new key.
